// File: rtl/snes_pad_reader.sv
// snes_pad_reader: polls two SNES serial pads and presents 16-bit button words (1 = pressed).
// Define SNES_PAD_DEBOUNCE_EN to only accept a frame that matches the previous poll's frame.
module snes_pad_reader #(
  parameter int CLK_DIV     = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_data1,
  input  logic        ctrl_data2,
  output logic        ctrl_latch,
  output logic        ctrl_clk,
  output logic [15:0] p1_buttons,
  output logic [15:0] p2_buttons,
  output logic        buttons_valid,
  output logic        busy
);
  localparam int TW = $clog2(POLL_PERIOD);
  localparam int PW = $clog2(2 * CLK_DIV);
  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0]   cap1_q, cap1_d, cap2_q, cap2_d;
  logic [15:0]   p1_q, p1_d, p2_q, p2_d;
  logic          latch_q, latch_d, clk_q, clk_d, valid_q, valid_d, busy_q, busy_d;
  logic          tc, last;
`ifdef SNES_PAD_DEBOUNCE_EN
  logic [15:0]   prev1_q, prev1_d, prev2_q, prev2_d;
`endif
  always_comb begin
    tc      = timer_q == TW'(POLL_PERIOD - 1);
    last    = phase_q == '0;
    timer_d = tc ? '0 : timer_q + 1'b1;
    phase_d = last ? phase_q : phase_q - 1'b1;
    sync1_d = {ctrl_data2, ctrl_data1};
    sync2_d = sync1_q;
    state_d = state_q;
    bit_d   = bit_q;
    cap1_d  = cap1_q;
    cap2_d  = cap2_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    latch_d = latch_q;
    clk_d   = clk_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
`ifdef SNES_PAD_DEBOUNCE_EN
    prev1_d = prev1_q;
    prev2_d = prev2_q;
`endif
    case (state_q)
      IDLE: if (tc) begin
        state_d = LATCH;
        phase_d = PW'(2 * CLK_DIV - 1);
        latch_d = 1'b1;
        busy_d  = 1'b1;
      end
      LATCH: if (last) begin
        state_d = LOW;
        phase_d = PW'(CLK_DIV - 1);
        latch_d = 1'b0;
        clk_d   = 1'b0;
        bit_d   = '0;
      end
      LOW: if (last) begin
        cap1_d[bit_q] = sync2_q[0];
        cap2_d[bit_q] = sync2_q[1];
        state_d = HIGH;
        phase_d = PW'(CLK_DIV - 1);
        clk_d   = 1'b1;
      end
      HIGH: if (last) begin
        if (bit_q == 4'd15) begin
          state_d = DONE;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = LOW;
          phase_d = PW'(CLK_DIV - 1);
          clk_d   = 1'b0;
          bit_d   = bit_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef SNES_PAD_DEBOUNCE_EN
        prev1_d = ~cap1_q;
        prev2_d = ~cap2_q;
        p1_d    = (~cap1_q == prev1_q) ? ~cap1_q : p1_q;
        p2_d    = (~cap2_q == prev2_q) ? ~cap2_q : p2_q;
`else
        p1_d    = ~cap1_q;
        p2_d    = ~cap2_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      phase_q <= '0;
      bit_q   <= '0;
      sync1_q <= '1;
      sync2_q <= '1;
      cap1_q  <= '0;
      cap2_q  <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      latch_q <= 1'b0;
      clk_q   <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SNES_PAD_DEBOUNCE_EN
      prev1_q <= '0;
      prev2_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cap1_q  <= cap1_d;
      cap2_q  <= cap2_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      latch_q <= latch_d;
      clk_q   <= clk_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef SNES_PAD_DEBOUNCE_EN
      prev1_q <= prev1_d;
      prev2_q <= prev2_d;
`endif
    end
  end
  assign ctrl_latch    = latch_q;
  assign ctrl_clk      = clk_q;
  assign p1_buttons    = p1_q;
  assign p2_buttons    = p2_q;
  assign buttons_valid = valid_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_snes_pad_reader.sv
// tb_snes_pad_reader: directed bench with shift-register pad models, CLK_DIV=4, POLL_PERIOD=200.
module tb_snes_pad_reader;
`ifdef SNES_PAD_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  logic        clock = 1'b0, reset_n = 1'b1;
  logic        ctrl_data1, ctrl_data2, ctrl_latch, ctrl_clk, buttons_valid, busy;
  logic [15:0] p1_buttons, p2_buttons;
  logic [15:0] raw1 = '1, raw2 = '1, sr1 = '1, sr2 = '1;
  logic        ovr_en = 1'b0, ovr_val = 1'b1;
  int          errors = 0, checks = 0;
  int          lat_first, lat_last, falls, lows, v_first, v_cnt, b_first, b_last, chg, idle_low;
  snes_pad_reader #(.CLK_DIV(4), .POLL_PERIOD(200)) dut (
    .clock(clock), .reset_n(reset_n), .ctrl_data1(ctrl_data1), .ctrl_data2(ctrl_data2),
    .ctrl_latch(ctrl_latch), .ctrl_clk(ctrl_clk), .p1_buttons(p1_buttons),
    .p2_buttons(p2_buttons), .buttons_valid(buttons_valid), .busy(busy)
  );
  always #5 clock = ~clock;
  // Pads load on latch and shift toward bit 0 on each rising ctrl_clk, filling with 1s.
  always @(posedge ctrl_latch or posedge ctrl_clk) begin
    if (ctrl_latch) begin
      sr1 <= raw1;
      sr2 <= raw2;
    end else begin
      sr1 <= {1'b1, sr1[15:1]};
      sr2 <= {1'b1, sr2[15:1]};
    end
  end
  assign ctrl_data1 = ovr_en ? ovr_val : sr1[0];
  assign ctrl_data2 = sr2[0];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input int cycles);
    logic       prev_clk;
    logic [15:0] prev_p1;
    lat_first = -1; lat_last = -1; falls = 0; lows = 0; v_first = -1; v_cnt = 0;
    b_first = -1; b_last = -1; chg = 0; idle_low = 0;
    prev_clk = ctrl_clk;
    prev_p1 = p1_buttons;
    for (int n = 1; n <= cycles; n++) begin
      @(negedge clock);
      if (ctrl_latch) begin
        if (lat_first < 0) lat_first = n;
        lat_last = n;
      end
      if (busy) begin
        if (b_first < 0) b_first = n;
        b_last = n;
      end
      if (buttons_valid) begin
        if (v_first < 0) v_first = n;
        v_cnt++;
      end
      if (prev_clk && !ctrl_clk) falls++;
      if (!ctrl_clk) lows++;
      if (!ctrl_clk && !busy) idle_low++;
      if (p1_buttons != prev_p1) chg++;
      prev_clk = ctrl_clk;
      prev_p1 = p1_buttons;
    end
  endtask
  task automatic wait_valid(input string tag);
    int i = 0;
    do begin
      @(negedge clock);
      i++;
    end while (!buttons_valid && i < 300);
    check(tag, buttons_valid, 1);
    @(negedge clock);
  endtask
  initial begin
    int i;
    #2 reset_n = 1'b0;
    #1;
    check("rst latch", ctrl_latch, 0);
    check("rst clk", ctrl_clk, 1);
    check("rst p1", p1_buttons, 0);
    check("rst valid", buttons_valid, 0);
    check("rst busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run(340);
    check("idle latch first", lat_first, 200);
    check("idle latch last", lat_last, 207);
    check("idle clk falls", falls, 16);
    check("idle clk lows", lows, 64);
    check("idle valid cyc", v_first, 336);
    check("idle valid cnt", v_cnt, 1);
    check("idle busy first", b_first, 200);
    check("idle busy last", b_last, 335);
    check("idle p1", p1_buttons, 16'h0000);
    check("idle p2", p2_buttons, 16'h0000);
    raw1 = 16'hF7F6;
    raw2 = 16'hFEFF;
    run(600);
    check("hold valid first", v_first, 196);
    check("hold valid cnt", v_cnt, 3);
    check("hold p1 changes", chg, 1);
    check("hold idle clk low", idle_low, 0);
    check("hold clk lows", lows, 192);
    check("press p1", p1_buttons, 16'h0809);
    check("press p2", p2_buttons, 16'h0100);
    run(125);
    check("pre-rst busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("midrst latch", ctrl_latch, 0);
    check("midrst clk", ctrl_clk, 1);
    check("midrst p1", p1_buttons, 0);
    check("midrst p2", p2_buttons, 0);
    check("midrst busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run(340);
    check("post-rst latch first", lat_first, 200);
    check("post-rst valid cyc", v_first, 336);
    check("post-rst valid cnt", v_cnt, 1);
    check("post-rst p1", p1_buttons, DB ? 16'h0000 : 16'h0809);
    raw1 = 16'hFFEF;
    raw2 = 16'hFFFF;
    wait_valid("up A valid");
    check("up single p1", p1_buttons, DB ? 16'h0000 : 16'h0010);
    raw1 = 16'hFFFF;
    wait_valid("up B valid");
    check("up released p1", p1_buttons, 16'h0000);
    raw1 = 16'hFFEF;
    wait_valid("up C valid");
    check("up first of two p1", p1_buttons, DB ? 16'h0000 : 16'h0010);
    wait_valid("up D valid");
    check("up second of two p1", p1_buttons, 16'h0010);
    check("up p2", p2_buttons, 16'h0000);
    raw1 = 16'hFFFF;
    ovr_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      ovr_val = 1'b1;
      i = 0;
      do begin
        @(negedge clock);
        i++;
      end while (!ctrl_latch && i < 300);
      check("sync latch seen", ctrl_latch, 1);
      repeat (11) @(negedge clock);
      ovr_val = 1'b0;
      repeat (14) @(negedge clock);
      ovr_val = 1'b1;
      repeat (10) @(negedge clock);
      ovr_val = 1'b0;
      wait_valid("sync valid");
    end
    check("sync p1", p1_buttons, 16'hFFF2);
    check("sync p2", p2_buttons, 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
